// File: rtl/pwm_voice_scheduler_if.sv
// Voice-side bus of the PWM voice scheduler: requests and amplitudes in, grant and PWM duty/status out.
// The master modport is the tone-voice side; the slave modport is the scheduler.
interface pwm_voice_scheduler_if #(
  parameter int NUM_VOICES = 4
);
  localparam int VW = $clog2(NUM_VOICES);

  logic [NUM_VOICES-1:0]   req;
  logic [NUM_VOICES*8-1:0] amp;
  logic [NUM_VOICES-1:0]   grant;
  logic [7:0]              duty_cycle;
  logic                    period_start;
  logic [VW-1:0]           active_voice;
  logic                    busy;

  modport master (
    output req, amp,
    input  grant, duty_cycle, period_start, active_voice, busy
  );

  modport slave (
    input  req, amp,
    output grant, duty_cycle, period_start, active_voice, busy
  );
endinterface

// File: rtl/pwm_voice_scheduler.sv
// Round-robin time-sharing of one 8-bit PWM stage among NUM_VOICES voices, switching only at period boundaries.
// Optional macro PWMSCHED_PRIO0_EN: voice 0 preempts any slot at a boundary without moving the RR pointer.
module pwm_voice_scheduler #(
  parameter int NUM_VOICES   = 4,
  parameter int SLOT_PERIODS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_voice_scheduler_if.slave  bus
);
  localparam int VW = $clog2(NUM_VOICES);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state;
  logic [7:0]            per;
  logic [3:0]            slot_cnt;
  logic [VW-1:0]         last_q;
  logic [NUM_VOICES-1:0] grant_q;
  logic [7:0]            duty_q;
  logic                  period_start_q;
  logic [VW-1:0]         active_q;
  logic                  busy_q;

  logic                  boundary;
  logic                  slot_end;
  logic                  any_req;
  logic                  prio_hit;
  logic [VW-1:0]         cand;
  logic [VW-1:0]         win_idx;
  logic [7:0]            win_amp;

  assign boundary = (per == 8'hFF);
  assign slot_end = (state == HOLD) && (slot_cnt == 4'(SLOT_PERIODS - 1));

  // Winner search starts one past the last RR grant and wraps.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_VOICES; i++) begin
      cand = VW'((int'(last_q) + i) % NUM_VOICES);
      if (!any_req && bus.req[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
`ifdef PWMSCHED_PRIO0_EN
    prio_hit = bus.req[0];
    if (prio_hit) win_idx = '0;
`else
    prio_hit = 1'b0;
`endif
    // Only the winner's amplitude slice is muxed, so X on other voices cannot leak.
    win_amp = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (win_idx == VW'(i)) win_amp = bus.amp[i*8 +: 8];
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      per            <= '0;
      slot_cnt       <= '0;
      last_q         <= VW'(NUM_VOICES - 1);
      grant_q        <= '0;
      duty_q         <= '0;
      period_start_q <= 1'b0;
      active_q       <= '0;
      busy_q         <= 1'b0;
    end else begin
      per            <= per + 8'd1;
      period_start_q <= boundary;
      grant_q        <= '0;
      if (boundary) begin
        if (prio_hit || (any_req && (state == IDLE || slot_end))) begin
          state            <= HOLD;
          duty_q           <= win_amp;
          grant_q[win_idx] <= 1'b1;
          active_q         <= win_idx;
          busy_q           <= 1'b1;
          slot_cnt         <= '0;
          if (!prio_hit) last_q <= win_idx;
        end else if (state == HOLD && !slot_end) begin
          slot_cnt <= slot_cnt + 4'd1;
        end else begin
          state  <= IDLE;
          duty_q <= '0;
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign bus.grant        = grant_q;
  assign bus.duty_cycle   = duty_q;
  assign bus.period_start = period_start_q;
  assign bus.active_voice = active_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_pwm_voice_scheduler.sv
// Directed bench: one scheduler with SLOT_PERIODS=1 (b1) and one with SLOT_PERIODS=3 (b3), both NUM_VOICES=4.
// Compile with PWMSCHED_PRIO0_EN defined to exercise the voice-0 override instead of plain round-robin.
module tb_pwm_voice_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] tb_per = '0;

  pwm_voice_scheduler_if #(.NUM_VOICES(4)) b1 ();
  pwm_voice_scheduler_if #(.NUM_VOICES(4)) b3 ();

  pwm_voice_scheduler #(.NUM_VOICES(4), .SLOT_PERIODS(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  pwm_voice_scheduler #(.NUM_VOICES(4), .SLOT_PERIODS(3)) d3 (.clk(clk), .rst(rst), .bus(b3));

  always #5 clk = ~clk;

  // Bench's own view of the period counter: zero in reset, +1 per clock, wraps at 256.
  always @(posedge clk) begin
    if (rst) tb_per <= '0;
    else     tb_per <= tb_per + 8'd1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic to_per(input logic [7:0] p);
    do @(negedge clk); while (tb_per != p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    logic [31:0] seen;
    b1.req = '0; b1.amp = '0; b3.req = '0; b3.amp = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({b1.grant, b1.duty_cycle, b1.busy, b1.active_voice, b1.period_start} !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0000",
               {b1.grant, b1.duty_cycle, b1.busy, b1.active_voice, b1.period_start});
    end
    rst = 1'b0;
    ok = 1'b1; seen = '0;
    repeat (255) begin
      @(negedge clk);
      if (ok && {b1.grant, b1.duty_cycle, b1.busy, b1.period_start, b3.grant, b3.duty_cycle} !== 26'h0) begin
        ok = 1'b0;
        seen = {6'h0, b1.grant, b1.duty_cycle, b1.busy, b1.period_start, b3.grant, b3.duty_cycle};
      end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL idle_after_reset: got %h want 0", seen); end
    @(negedge clk);
    total++;
    if ({b1.period_start, b1.duty_cycle, b1.busy, b1.grant} !== {1'b1, 8'h00, 1'b0, 4'h0}) begin
      bad++;
      $display("FAIL first_period_start: got %h want %h",
               {b1.period_start, b1.duty_cycle, b1.busy, b1.grant}, {1'b1, 8'h00, 1'b0, 4'h0});
    end
  endtask

  task automatic test_single();
    b1.amp = 32'h0000_0080;
    b1.req = 4'b0001;
    to_per(8'd0);
    total++;
    if ({b1.grant, b1.duty_cycle, b1.busy, b1.active_voice, b1.period_start} !==
        {4'b0001, 8'h80, 1'b1, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL single_grant: got %h want %h",
               {b1.grant, b1.duty_cycle, b1.busy, b1.active_voice, b1.period_start},
               {4'b0001, 8'h80, 1'b1, 2'd0, 1'b1});
    end
    b1.req = '0;
    @(negedge clk);
    total++;
    if ({b1.grant, b1.duty_cycle, b1.busy} !== {4'b0000, 8'h80, 1'b1}) begin
      bad++;
      $display("FAIL grant_one_cycle: got %h want %h", {b1.grant, b1.duty_cycle, b1.busy}, {4'b0000, 8'h80, 1'b1});
    end
    to_per(8'd0);
    total++;
    if ({b1.grant, b1.duty_cycle, b1.busy} !== {4'b0000, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL single_release: got %h want %h", {b1.grant, b1.duty_cycle, b1.busy}, {4'b0000, 8'h00, 1'b0});
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_duty [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
    int v;
    do_reset();
    b1.amp = 32'h4030_2010;
    b1.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      v = k % 4;
      to_per(8'd0);
      total++;
      if ({b1.grant, b1.duty_cycle, b1.active_voice, b1.busy} !== {4'(1 << v), exp_duty[k], 2'(v), 1'b1}) begin
        bad++;
        $display("FAIL rr_grant_%0d: got %h want %h", k,
                 {b1.grant, b1.duty_cycle, b1.active_voice, b1.busy}, {4'(1 << v), exp_duty[k], 2'(v), 1'b1});
      end
      to_per(8'd128);
      total++;
      if ({b1.grant, b1.duty_cycle} !== {4'b0000, exp_duty[k]}) begin
        bad++;
        $display("FAIL rr_midperiod_%0d: got %h want %h", k, {b1.grant, b1.duty_cycle}, {4'b0000, exp_duty[k]});
      end
    end
    b1.req = '0;
  endtask

  task automatic test_amp_zero();
    // RR pointer sits at voice 0; only voice 2 requests, and the other amplitude lanes are X.
    b1.amp = {8'hxx, 8'h00, 8'hxx, 8'hxx};
    b1.req = 4'b0100;
    to_per(8'd0);
    total++;
    if ({b1.grant, b1.duty_cycle, b1.active_voice, b1.busy} !== {4'b0100, 8'h00, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL amp_zero_grant: got %h want %h",
               {b1.grant, b1.duty_cycle, b1.active_voice, b1.busy}, {4'b0100, 8'h00, 2'd2, 1'b1});
    end
    b1.req = '0;
    b1.amp = '0;
  endtask

  task automatic test_slot3();
    bit ok;
    logic [11:0] seen;
    do_reset();
    b3.amp = 32'h00AA_5500;
    b3.req = 4'b0110;
    to_per(8'd0);
    total++;
    if ({b3.grant, b3.duty_cycle, b3.active_voice, b3.busy} !== {4'b0010, 8'h55, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL slot3_first: got %h want %h",
               {b3.grant, b3.duty_cycle, b3.active_voice, b3.busy}, {4'b0010, 8'h55, 2'd1, 1'b1});
    end
    ok = 1'b1; seen = '0;
    repeat (767) begin
      @(negedge clk);
      if (ok && {b3.grant, b3.duty_cycle} !== {4'b0000, 8'h55}) begin
        ok = 1'b0;
        seen = {b3.grant, b3.duty_cycle};
      end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL slot3_hold: got %h want 055", seen); end
    @(negedge clk);
    total++;
    if ({b3.grant, b3.duty_cycle, b3.active_voice, b3.busy} !== {4'b0100, 8'hAA, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL slot3_second: got %h want %h",
               {b3.grant, b3.duty_cycle, b3.active_voice, b3.busy}, {4'b0100, 8'hAA, 2'd2, 1'b1});
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [12:0] seen;
    to_per(8'd100);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({b3.grant, b3.duty_cycle, b3.busy, b3.active_voice, b3.period_start} !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_clear: got %h want 0000",
               {b3.grant, b3.duty_cycle, b3.busy, b3.active_voice, b3.period_start});
    end
    rst = 1'b0;
    b3.amp = 32'h00AA_0011;
    b3.req = 4'b0101;
    ok = 1'b1; seen = '0;
    repeat (255) begin
      @(negedge clk);
      if (ok && {b3.grant, b3.duty_cycle, b3.busy} !== 13'h0) begin
        ok = 1'b0;
        seen = {b3.grant, b3.duty_cycle, b3.busy};
      end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL reset_mid_wait: got %h want 0", seen); end
    @(negedge clk);
    total++;
    if ({b3.grant, b3.duty_cycle, b3.active_voice, b3.busy, b3.period_start} !==
        {4'b0001, 8'h11, 2'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid_regrant: got %h want %h",
               {b3.grant, b3.duty_cycle, b3.active_voice, b3.busy, b3.period_start},
               {4'b0001, 8'h11, 2'd0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_voice0_midslot();
    do_reset();
    b3.amp = 32'h33AA_2211;
    b3.req = 4'b0100;
    to_per(8'd0);
    total++;
    if ({b3.grant, b3.duty_cycle, b3.active_voice} !== {4'b0100, 8'hAA, 2'd2}) begin
      bad++;
      $display("FAIL v2_slot_start: got %h want %h", {b3.grant, b3.duty_cycle, b3.active_voice}, {4'b0100, 8'hAA, 2'd2});
    end
    b3.req = 4'b0001;
    to_per(8'd0);
`ifdef PWMSCHED_PRIO0_EN
    total++;
    if ({b3.grant, b3.duty_cycle, b3.active_voice, b3.busy} !== {4'b0001, 8'h11, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL prio0_preempt: got %h want %h",
               {b3.grant, b3.duty_cycle, b3.active_voice, b3.busy}, {4'b0001, 8'h11, 2'd0, 1'b1});
    end
    b3.req = 4'b1010;
    to_per(8'd0);
    total++;
    if ({b3.grant, b3.duty_cycle} !== {4'b0000, 8'h11}) begin
      bad++;
      $display("FAIL prio0_hold: got %h want %h", {b3.grant, b3.duty_cycle}, {4'b0000, 8'h11});
    end
    to_per(8'd0);
    to_per(8'd0);
    total++;
    if ({b3.grant, b3.duty_cycle, b3.active_voice} !== {4'b1000, 8'h33, 2'd3}) begin
      bad++;
      $display("FAIL prio0_rr_resume: got %h want %h", {b3.grant, b3.duty_cycle, b3.active_voice}, {4'b1000, 8'h33, 2'd3});
    end
`else
    total++;
    if ({b3.grant, b3.duty_cycle, b3.active_voice} !== {4'b0000, 8'hAA, 2'd2}) begin
      bad++;
      $display("FAIL no_preempt: got %h want %h", {b3.grant, b3.duty_cycle, b3.active_voice}, {4'b0000, 8'hAA, 2'd2});
    end
    to_per(8'd0);
    to_per(8'd0);
    total++;
    if ({b3.grant, b3.duty_cycle, b3.active_voice} !== {4'b0001, 8'h11, 2'd0}) begin
      bad++;
      $display("FAIL v0_after_slot: got %h want %h", {b3.grant, b3.duty_cycle, b3.active_voice}, {4'b0001, 8'h11, 2'd0});
    end
`endif
    b3.req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_amp_zero();
    test_slot3();
    test_reset_mid();
    test_voice0_midslot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_voice_scheduler.md
Name: pwm_voice_scheduler

Overview:
Time-shares one 8-bit PWM output stage among NUM_VOICES tone voices. Keeps an internal 256-clock period counter aligned with the PWM counter. Arbitrates round-robin among requesting voices at period boundaries and drives the PWM `duty_cycle` input glitch-free, never mid-period. Sits between the tone-generator voices and the PWM output block.

Parameters:
- NUM_VOICES, 4, number of requesters; legal range 2..8.
- SLOT_PERIODS, 1, number of PWM periods a granted voice holds the output; legal range 1..15.
- VW, clog2(NUM_VOICES), localparam; width of the voice index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  NUM_VOICES  per-voice request level; held until granted
- amp  in  NUM_VOICES*8  per-voice amplitude; voice i uses bits [8i+7:8i]; must be stable while req[i] is high
- grant  out  NUM_VOICES  one-hot, one-cycle pulse; amp of that voice was captured
- duty_cycle  out  8  duty value to the PWM stage
- period_start  out  1  high during the first clock of each PWM period (per==0 after a wrap)
- active_voice  out  VW  index of the voice currently owning the output
- busy  out  1  a voice owns the current period

Behaviour:
- Reset (synchronous, rst=1 at clk edge) sets the following:
  - per=0, slot_cnt=0, duty_cycle=0, grant=0, period_start=0, active_voice=0, busy=0.
  - RR pointer last=NUM_VOICES-1, so voice 0 has first priority.
- per is 8-bit and increments every clock, wrapping 255->0. It has no enable.
- period_start is registered as (per==255). The first pulse after reset release occurs 256 clocks later, not at release.
- All decisions are taken only at the edge where per==255 (the boundary). Between boundaries, duty_cycle, busy and active_voice are frozen.
- State machine:
  - IDLE:
    - Boundary with req!=0: arbitrate and go to HOLD.
    - Boundary with req==0: duty_cycle<=0, busy<=0, active_voice holds its value.
  - HOLD:
    - Boundary with slot_cnt<SLOT_PERIODS-1: slot_cnt++; duty and grant are unchanged.
    - Boundary with slot_cnt==SLOT_PERIODS-1: slot ends. If req!=0, arbitrate and stay in HOLD. Otherwise go to IDLE with duty_cycle<=0, busy<=0.
- Arbitrate means:
  - Winner w = first set req bit searching from last+1 upward, wrapping modulo NUM_VOICES.
  - On the same edge: duty_cycle<=amp[w], grant[w]<=1, active_voice<=w, last<=w, busy<=1, slot_cnt<=0.
- Latency:
  - grant and new duty_cycle are both visible in the cycle where per==0 and period_start==1.
  - grant clears the following cycle.
- Handshake:
  - amp is sampled only at the grant edge.
  - A requester deasserts req in the cycle after grant.
  - If req stays high, it is treated as a new request, eligible at the next slot end. The RR pointer keeps it from starving others.
- Simultaneous events:
  - req rising on the boundary edge itself is honoured on that edge.
  - A voice dropping req before its grant simply loses; no grant is issued.
- amp==0 is a legal grant: duty_cycle=0 with busy=1.
- Reset mid-slot clears everything on that edge. Pending grants are lost. Requesters still holding req are re-arbitrated at the first boundary, 256 clocks after release.
- X on unused amp bits must not propagate: only amp[w] is muxed.

Optional Feature:
- Macro PWMSCHED_PRIO0_EN.
- Defined:
  - Voice 0 is a fixed-priority override (e.g. alarm tone).
  - At any boundary where req[0]=1, voice 0 wins even mid-slot of another voice. That voice's slot is truncated, and last is not updated by the preemption.
- Undefined:
  - Pure round-robin as above; voice 0 has no special treatment.
  - No extra logic is synthesised.

Test Plan:
- Reset release with req=0 -> duty_cycle=0, busy=0, grant=0 for all 256 clocks; single period_start pulse at clock 256; duty stays 0.
- NUM_VOICES=4, SLOT_PERIODS=1, req=0001, amp0=0x80 before the first boundary -> grant=0001 for exactly 1 cycle at clock 256, duty_cycle=0x80, busy=1, active_voice=0. req dropped -> next boundary duty=0, busy=0.
- req=1111 held, amps 0x10/0x20/0x30/0x40 -> grants in order 0,1,2,3,0 at successive boundaries; duty 0x10,0x20,0x30,0x40,0x10; never changes when per!=0.
- SLOT_PERIODS=3, req=0110 held -> voice 1 holds duty for 768 clocks with a single grant, then voice 2 for 768 clocks.
- Reset asserted at per=100 during a HOLD of voice 2 -> next edge: all outputs 0, per=0. Voice 0 wins the first boundary 256 clocks after release when req=0101.
- PWMSCHED_PRIO0_EN defined, voice 2 in a SLOT_PERIODS=3 slot, req[0] rises -> voice 0 granted at the next boundary. The following RR arbitration starts from voice 3.
